// File: rtl/hazard_controller.sv
// rtl/hazard_controller.sv - 5-stage pipeline hazard control: load-use stall, flushes, forwarding selects
module hazard_controller #(
  parameter int REG_BITS = 5,
  parameter int CNT_BITS = 16
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                id_valid,
  input  logic [2:0]          id_irj,
  input  logic [REG_BITS-1:0] id_rs,
  input  logic [REG_BITS-1:0] id_rt,
  input  logic [REG_BITS-1:0] id_rd,
  input  logic                id_is_load,
  input  logic                id_rt_src,
  input  logic                ex_branch_taken,
  output logic                stall,
  output logic                flush_if,
  output logic                flush_id,
  output logic [1:0]          fwd_a,
  output logic [1:0]          fwd_b,
  output logic [CNT_BITS-1:0] stall_cnt
);

  localparam logic [2:0] TYPE_I = 3'b100;
  localparam logic [2:0] TYPE_R = 3'b010;
  localparam logic [2:0] TYPE_J = 3'b001;

  typedef struct packed {
    logic                valid;
    logic [REG_BITS-1:0] dest;
    logic                is_load;
  } entry_t;

  // index 0 = EX, 1 = MEM, 2 = WB
  entry_t shadow [3];

  logic                is_r, is_i, is_j;
  logic                has_dest, rs_en, rt_en;
  logic [REG_BITS-1:0] dest_raw;
  logic                load_use;
  logic [1:0]          sel_a, sel_b;

  assign is_r = id_valid && (id_irj == TYPE_R);
  assign is_i = id_valid && (id_irj == TYPE_I);
  assign is_j = id_valid && (id_irj == TYPE_J);

  assign dest_raw = is_r ? id_rd : id_rt;
  assign has_dest = (is_r || (is_i && !id_rt_src)) && (dest_raw != '0);
  assign rs_en    = (is_r || is_i) && (id_rs != '0);
  assign rt_en    = (is_r || (is_i && id_rt_src)) && (id_rt != '0);

  function automatic logic hits(input entry_t e, input logic en, input logic [REG_BITS-1:0] r);
    return e.valid && en && (e.dest == r);
  endfunction

  // The EX entry becomes MEM next cycle, so "01" selects the MEM-stage result.
  function automatic logic [1:0] fwd_sel(input logic en, input logic [REG_BITS-1:0] r,
                                         input entry_t ex_e, input entry_t mem_e);
    if (hits(ex_e, en, r))       return 2'b01;
    else if (hits(mem_e, en, r)) return 2'b10;
    else                         return 2'b00;
  endfunction

  assign load_use = shadow[0].valid && shadow[0].is_load &&
                    (hits(shadow[0], rs_en, id_rs) || hits(shadow[0], rt_en, id_rt));

  assign stall    = load_use && !ex_branch_taken;
  assign flush_id = stall || ex_branch_taken;
  assign flush_if = ex_branch_taken || (is_j && !stall);

  assign sel_a = fwd_sel(rs_en, id_rs, shadow[0], shadow[1]);
  assign sel_b = fwd_sel(rt_en, id_rt, shadow[0], shadow[1]);

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 3; i++) shadow[i] <= '0;
      fwd_a     <= 2'b00;
      fwd_b     <= 2'b00;
      stall_cnt <= '0;
    end else begin
      shadow[2] <= shadow[1];
      shadow[1] <= shadow[0];
      if (flush_id) begin
        shadow[0] <= '0;
        fwd_a     <= 2'b00;
        fwd_b     <= 2'b00;
      end else begin
        shadow[0] <= '{valid: has_dest, dest: dest_raw, is_load: id_is_load};
        fwd_a     <= sel_a;
        fwd_b     <= sel_b;
      end
      if (stall && (stall_cnt != '1)) stall_cnt <= stall_cnt + 1'b1;
    end
  end

endmodule

// File: tb/tb_hazard_controller.sv
// tb/tb_hazard_controller.sv - randomized and directed checks of hazard_controller against a pipeline model
module tb_hazard_controller;

  logic       clk = 1'b0;
  logic       rst;
  logic       id_valid;
  logic [2:0] id_irj;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_is_load, id_rt_src, ex_branch_taken;
  logic       stall, flush_if, flush_id;
  logic [1:0] fwd_a, fwd_b;
  logic [15:0] stall_cnt;
  logic       stall2, flush_if2, flush_id2;
  logic [1:0] fwd_a2, fwd_b2;
  logic [1:0] stall_cnt2;

  always #5 clk = ~clk;

  hazard_controller #(.REG_BITS(5), .CNT_BITS(16)) dut (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_irj(id_irj),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_is_load(id_is_load),
    .id_rt_src(id_rt_src), .ex_branch_taken(ex_branch_taken),
    .stall(stall), .flush_if(flush_if), .flush_id(flush_id),
    .fwd_a(fwd_a), .fwd_b(fwd_b), .stall_cnt(stall_cnt)
  );

  hazard_controller #(.REG_BITS(5), .CNT_BITS(2)) dut_small (
    .clk(clk), .rst(rst), .id_valid(id_valid), .id_irj(id_irj),
    .id_rs(id_rs), .id_rt(id_rt), .id_rd(id_rd), .id_is_load(id_is_load),
    .id_rt_src(id_rt_src), .ex_branch_taken(ex_branch_taken),
    .stall(stall2), .flush_if(flush_if2), .flush_id(flush_id2),
    .fwd_a(fwd_a2), .fwd_b(fwd_b2), .stall_cnt(stall_cnt2)
  );

  int n_cmp = 0;
  int n_bad = 0;

  task automatic check(input string tag, input int got, input int exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Model: in-flight instructions as queues, element 0 = EX, 1 = MEM, 2 = WB; dest -1 = nothing written.
  int q_dest[$];
  bit q_load[$];
  int m_fa, m_fb, m_cnt, m_cnt2;
  bit obs_stall, obs_fif, obs_fid;

  task automatic model_reset();
    q_dest = '{-1, -1, -1};
    q_load = '{0, 0, 0};
    m_fa = 0; m_fb = 0; m_cnt = 0; m_cnt2 = 0;
  endtask

  function automatic int fwd_of(input int src);
    if (src <= 0) return 0;
    if (q_dest[0] == src) return 1;
    if (q_dest[1] == src) return 2;
    return 0;
  endfunction

  task automatic step(input bit r, input bit v, input logic [2:0] irj, input int rs, input int rt,
                      input int rd, input bit ld, input bit rsrc, input bit br);
    int dest, src_a, src_b;
    bit hz, m_stall, m_fid, m_fif;
    @(negedge clk);
    rst = r; id_valid = v; id_irj = irj; id_rs = 5'(rs); id_rt = 5'(rt); id_rd = 5'(rd);
    id_is_load = ld; id_rt_src = rsrc; ex_branch_taken = br;
    #1;
    dest = -1; src_a = -1; src_b = -1;
    if (v && irj == 3'b010) begin dest = rd; src_a = rs; src_b = rt; end
    if (v && irj == 3'b100) begin
      src_a = rs;
      if (rsrc) src_b = rt; else dest = rt;
    end
    if (dest == 0) dest = -1;
    if (src_a == 0) src_a = -1;
    if (src_b == 0) src_b = -1;
    hz = q_load[0] && q_dest[0] >= 0 && (q_dest[0] == src_a || q_dest[0] == src_b);
    m_stall = hz && !br;
    m_fid = m_stall || br;
    m_fif = br || (v && irj == 3'b001 && !m_stall);
    check("stall", stall, m_stall);
    check("flush_id", flush_id, m_fid);
    check("flush_if", flush_if, m_fif);
    check("fwd_a", fwd_a, m_fa);
    check("fwd_b", fwd_b, m_fb);
    check("stall_cnt", stall_cnt, m_cnt);
    check("stall_cnt_small", stall_cnt2, m_cnt2);
    obs_stall = stall; obs_fif = flush_if; obs_fid = flush_id;
    if (r) model_reset();
    else begin
      m_fa = m_fid ? 0 : fwd_of(src_a);
      m_fb = m_fid ? 0 : fwd_of(src_b);
      q_dest.push_front(m_fid ? -1 : dest);
      q_load.push_front(m_fid ? 1'b0 : ld);
      void'(q_dest.pop_back());
      void'(q_load.pop_back());
      if (m_stall) begin
        if (m_cnt < 65535) m_cnt++;
        if (m_cnt2 < 3) m_cnt2++;
      end
    end
    @(posedge clk);
  endtask

  task automatic idle();
    step(0, 0, 3'b010, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic do_reset();
    step(1, 0, 3'b010, 0, 0, 0, 0, 0, 0);
    step(1, 0, 3'b010, 0, 0, 0, 0, 0, 0);
  endtask

  initial begin
    rst = 1; id_valid = 0; id_irj = 3'b010; id_rs = 0; id_rt = 0; id_rd = 0;
    id_is_load = 0; id_rt_src = 0; ex_branch_taken = 0;
    model_reset();

    do_reset();
    idle();
    check("idle_stall", stall, 0);
    check("idle_fwd_a", fwd_a, 0);
    check("idle_cnt", stall_cnt, 0);

    // add $t0,$t1,$t2 then add $t3,$t0,$t0
    step(0, 1, 3'b010, 9, 10, 8, 0, 0, 0);
    step(0, 1, 3'b010, 8, 8, 11, 0, 0, 0);
    check("alu_nostall", obs_stall, 0);
    #1;
    check("alu_fwd_a", fwd_a, 1);
    check("alu_fwd_b", fwd_b, 1);

    // addi $t1,$t2,9 ; unrelated ; add $t0,$t1,$t2
    step(0, 1, 3'b100, 10, 9, 0, 0, 0, 0);
    step(0, 1, 3'b010, 20, 21, 22, 0, 0, 0);
    step(0, 1, 3'b010, 9, 10, 8, 0, 0, 0);
    #1;
    check("mem_fwd_a", fwd_a, 2);
    check("mem_fwd_b", fwd_b, 0);

    // lw $t1 then add $t0,$t1,$t2: one stall, then WB forward
    do_reset();
    step(0, 1, 3'b100, 29, 9, 0, 1, 0, 0);
    step(0, 1, 3'b010, 9, 10, 8, 0, 0, 0);
    check("lu_stall", obs_stall, 1);
    check("lu_flush_id", obs_fid, 1);
    step(0, 1, 3'b010, 9, 10, 8, 0, 0, 0);
    check("lu_stall_once", obs_stall, 0);
    #1;
    check("lu_fwd_a", fwd_a, 2);
    check("lu_cnt", stall_cnt, 1);

    // jump
    step(0, 1, 3'b001, 0, 0, 0, 0, 0, 0);
    check("j_flush_if", obs_fif, 1);
    idle();
    check("j_once", obs_fif, 0);

    // taken branch over a load-use hazard
    step(0, 1, 3'b100, 29, 9, 0, 1, 0, 0);
    step(0, 1, 3'b010, 9, 10, 8, 0, 0, 1);
    check("br_stall", obs_stall, 0);
    check("br_flush_if", obs_fif, 1);
    check("br_flush_id", obs_fid, 1);
    #1;
    check("br_cnt", stall_cnt, 1);

    // lw $0 then reader of $0
    step(0, 1, 3'b100, 29, 0, 0, 1, 0, 0);
    step(0, 1, 3'b010, 0, 0, 8, 0, 0, 0);
    check("zero_nostall", obs_stall, 0);

    // saturation of the 2-bit counter
    do_reset();
    for (int k = 0; k < 5; k++) begin
      step(0, 1, 3'b100, 29, 9, 0, 1, 0, 0);
      step(0, 1, 3'b010, 9, 10, 8, 0, 0, 0);
      step(0, 1, 3'b010, 9, 10, 8, 0, 0, 0);
    end
    #1;
    check("sat_small", stall_cnt2, 3);
    check("sat_big", stall_cnt, 5);

    // randomized traffic on a small register set to provoke hazards, with occasional reset
    for (int n = 0; n < 800; n++) begin
      logic [2:0] irj;
      case ($urandom_range(0, 2))
        0: irj = 3'b100;
        1: irj = 3'b010;
        default: irj = 3'b001;
      endcase
      step($urandom_range(0, 49) == 0, $urandom_range(0, 7) != 0, irj,
           $urandom_range(0, 3), $urandom_range(0, 3), $urandom_range(0, 3),
           $urandom_range(0, 2) == 0, $urandom_range(0, 1), $urandom_range(0, 9) == 0);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
